// File: rtl/mul_acc_stage.sv
// mul_acc_stage
// Accumulates a stream of unsigned multiplier products into one dot-product
// result. Each sum is delimited by in_last. The finished sum is held on the
// output side until the consumer takes it. The stage also reports how many
// terms went into the sum and whether the sum wrapped.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   product beat valid
//   in_ready   stage can accept a beat (depends on state only)
//   in_prod    unsigned product, PROD_W bits
//   in_last    beat is the final term of the current sum
//   flush      discards a partial accumulation; has no effect while holding
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_acc    accumulated sum modulo 2^ACC_W
//   out_count  number of terms, saturating at 2^CNT_W-1
//   out_ovf    sum wrapped past 2^ACC_W-1 at least once
module mul_acc_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W:0]     sum_w;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_next;
    logic               accept;

    // Widened add: the top bit is the carry out of the ACC_W-bit accumulator.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0]  a,
                                               input logic [PROD_W-1:0] p);
        return {1'b0, a} + (ACC_W+1)'(p);
    endfunction

    // Term counter sticks at all-ones; saturation is not an overflow.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign in_ready  = (state_q != HOLD);
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    assign accept   = in_valid & in_ready & ~flush;
    assign sum_w    = add_ext(acc_q, in_prod);
    assign cnt_inc  = sat_inc(cnt_q);
    assign ovf_next = ovf_q | sum_w[ACC_W];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (flush) begin
                    // Flush beats any beat presented in the same cycle.
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end else if (accept) begin
                    if (in_last) begin
                        // Publish the post-add values and restart the sum.
                        out_acc_d   = sum_w[ACC_W-1:0];
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d   = sum_w[ACC_W-1:0];
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_next;
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                // Result fields keep their value after the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_acc_stage.sv
// tb_mul_acc_stage
// Directed bench for mul_acc_stage. A behavioural model tracks the true
// (unbounded) sum and term count of each dot product and derives the
// expected outputs arithmetically. A compare process checks the DUT against
// the model on every falling edge. Literal checks in the stimulus pin the
// model to hand-computed values.
module tb_mul_acc_stage;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic              in_last = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mul_acc_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: true sum of the terms so far, number of terms,
    // and the published result while a result is being presented.
    bit     m_hold = 1'b0;
    longint m_sum  = 0;
    longint m_n    = 0;
    longint m_oacc = 0;
    longint m_ocnt = 0;
    longint m_oovf = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 1'b0; m_sum = 0; m_n = 0;
            m_oacc = 0; m_ocnt = 0; m_oovf = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (flush) begin
            m_sum = 0; m_n = 0;
        end else if (in_valid) begin
            m_sum += longint'(in_prod);
            m_n++;
            if (in_last) begin
                m_oacc = m_sum % (64'd1 << ACC_W);
                m_ocnt = (m_n > 255) ? 255 : m_n;
                m_oovf = (m_sum >= (64'd1 << ACC_W)) ? 1 : 0;
                m_hold = 1'b1;
                m_sum = 0; m_n = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  longint'(in_ready),  m_hold ? 0 : 1);
            check("out_valid", longint'(out_valid), m_hold ? 1 : 0);
            check("out_acc",   longint'(out_acc),   m_oacc);
            check("out_count", longint'(out_count), m_ocnt);
            check("out_ovf",   longint'(out_ovf),   m_oovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic beat(input logic [PROD_W-1:0] p, input logic last);
        bit took;
        took = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        for (int i = 0; i < 50 && !took; i++) begin
            took = in_ready && !flush;
            tick();
        end
        if (!took) check("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string name, input longint v, input longint acc,
                              input longint cnt, input longint ovf);
        check({name, "_valid"}, longint'(out_valid), v);
        check({name, "_acc"},   longint'(out_acc),   acc);
        check({name, "_count"}, longint'(out_count), cnt);
        check({name, "_ovf"},   longint'(out_ovf),   ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        expect_out("reset", 0, 0, 0, 0);
        check("reset_in_ready", longint'(in_ready), 1);

        // Basic 3-term sum
        out_ready = 1'b1;
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        beat(16'd300, 1'b1);
        expect_out("sum3", 1, 600, 3, 0);
        check("sum3_in_ready_hold", longint'(in_ready), 0);
        tick();
        check("sum3_valid_drop", longint'(out_valid), 0);
        check("sum3_in_ready_back", longint'(in_ready), 1);
        check("sum3_acc_kept", longint'(out_acc), 600);

        // Single beat, max operand
        beat(16'hFE01, 1'b1);
        expect_out("single", 1, 32'h00FE01, 1, 0);
        tick();

        // Overflow and count saturation
        for (int i = 0; i < 259; i++) beat(16'd65025, (i == 258));
        expect_out("ovf", 1, 64259, 255, 1);
        tick();

        // Backpressure
        out_ready = 1'b0;
        beat(16'd7, 1'b0);
        beat(16'd9, 1'b1);
        in_valid = 1'b1; in_prod = 16'd50; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_acc", longint'(out_acc), 16);
            check("bp_valid", longint'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        beat(16'd50, 1'b1);
        expect_out("bp_next", 1, 50, 1, 0);
        tick();

        // Flush with a simultaneous last beat, then flush during HOLD
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_prod = 16'd99; in_last = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        beat(16'd5, 1'b1);
        expect_out("flush", 1, 5, 1, 0);
        flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        expect_out("flush_hold", 1, 5, 1, 0);
        out_ready = 1'b1;
        tick();
        check("flush_done", longint'(out_valid), 0);

        // Reset in ACCUM
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_accum", 0, 0, 0, 0);
        check("rst_accum_in_ready", longint'(in_ready), 1);

        // Reset in HOLD
        out_ready = 1'b0;
        beat(16'd4, 1'b1);
        check("pre_rst_hold_valid", longint'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_hold", 0, 0, 0, 0);
        check("rst_hold_in_ready", longint'(in_ready), 1);
        out_ready = 1'b1;
        beat(16'd3, 1'b1);
        expect_out("after_rst", 1, 3, 1, 0);
        tick(); tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_acc_stage.md
Name: mul_acc_stage

Overview:
Downstream consumer of the 8x8 multiplier's 16-bit product. It accumulates a stream of products into one dot-product result, delimited by a last flag. Handshakes are valid/ready on both sides. It holds the finished result until the consumer takes it, and reports overflow and term count alongside the sum.

Parameters:
PROD_W, 16, product width (matches multiplier output)
ACC_W, 24, accumulator/result width; must be >= PROD_W
CNT_W, 8, term-counter width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_prod  input  PROD_W  unsigned product from multiplier
in_last  input  1  beat is final term of current sum
flush  input  1  discard partial accumulation (sync)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_acc  output  ACC_W  accumulated sum (mod 2^ACC_W)
out_count  output  CNT_W  number of terms in sum, saturating
out_ovf  output  1  sum wrapped past 2^ACC_W-1 at least once

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named rst. No asynchronous reset anywhere.
- States:
  - IDLE: no terms held.
  - ACCUM: at least 1 term held.
  - HOLD: result presented.
- Reset (sync, rst=1 at edge):
  - state=IDLE; internal acc=0, cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - rst overrides every other input, in any state, including mid-HOLD. A held result is lost.
- in_ready = (state != HOLD). It is combinational from state only, with no dependence on in_valid or out_ready.
- Accept = in_valid & in_ready & ~flush at the rising edge. On accept:
  - acc <= acc + zero-extended in_prod, truncated to ACC_W.
  - ovf <= ovf | carry-out of that add (sticky).
  - cnt <= cnt+1, saturating at 2^CNT_W-1. Saturation does not set ovf.
- Accept with in_last=0: state <= ACCUM.
- Accept with in_last=1:
  - out_acc, out_count and out_ovf are loaded with the post-add values.
  - out_valid <= 1; state <= HOLD.
  - Internal acc, cnt and ovf clear to 0.
  - Latency: result visible in the cycle after the edge that accepted the last beat.
- A single beat with in_last=1 from IDLE is legal: IDLE->HOLD directly.
- HOLD:
  - out_valid=1. out_acc, out_count and out_ovf stay stable until out_ready=1.
  - On out_valid & out_ready: out_valid <= 0 and state <= IDLE. The next beat can be accepted the following cycle; there is no same-cycle pass-through.
  - out_acc, out_count and out_ovf keep their last value after the handshake; they are not cleared.
- flush=1 in IDLE/ACCUM:
  - acc, cnt and ovf <= 0; state <= IDLE.
  - A beat presented in the same cycle is dropped, even though in_ready=1. Flush wins, including over in_last.
- flush=1 in HOLD: ignored. The result is still delivered.
- in_valid with in_ready=0 (HOLD): no effect. The upstream stage must hold the beat.
- The datapath is unsigned only, with no rounding.

Test Plan:
- Basic 3-term sum: after rst, beats 100, 200, 300 (last on 300), out_ready=1 → out_valid for exactly 1 cycle, the cycle after the 3rd accept. Expect out_acc=600, out_count=3, out_ovf=0. in_ready returns high the next cycle.
- Single-beat, max operand: one beat 0xFE01 (255*255) with in_last=1 → out_acc=0x00FE01, out_count=1, out_ovf=0. State goes IDLE→HOLD directly.
- Overflow and count saturation: 259 beats of 65025, last on the 259th → out_acc=64259 (16841475 mod 2^24), out_ovf=1, out_count=255 (saturated).
- Backpressure: complete a sum of 7+9=16, hold out_ready=0 for 5 cycles with in_valid=1 and in_prod=50 → in_ready=0 throughout, out_acc=16 stable, the 50 beat is not absorbed. Release out_ready; the 50 beat is accepted on a later cycle and starts a new sum.
- Flush: beats 10 and 20, then flush with a simultaneous beat 99 (last), then beat 5 (last) → the 99 beat is dropped. Expect out_acc=5, out_count=1. A further flush asserted during HOLD leaves out_acc=5 delivered unchanged.
- Reset mid-operation: rst asserted in ACCUM after 2 beats, and separately in HOLD with out_ready=0 → the next cycle shows out_valid=0, all outputs 0, in_ready=1. A following beat 3 (last) gives out_acc=3, out_count=1.
